bcd_result_display: RTL

- Downstream stage of the two-digit BCD add/subtract calculator.
- Accepts one result per handshake: two BCD digits, carry-out and the add/subtract mode.
- Resolves sign: a subtract with no carry is negative, and its magnitude is recovered sequentially by a 10's complement, one digit per cycle.
- Drives three active-low 7-segment displays, with a blinking error indication for non-BCD input.

---
 rtl/bcd_result_display_if.sv | 10 +
 rtl/bcd_result_display.sv | 104 ++++++++++
 2 files changed

// File: rtl/bcd_result_display_if.sv
// bcd_result_display_if: result handshake between the BCD calculator and the display stage.
interface bcd_result_display_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] result;
  logic       carry;
  logic       mode_sub;
  modport master (output in_valid, result, carry, mode_sub, input in_ready);
  modport slave  (input in_valid, result, carry, mode_sub, output in_ready);
endinterface

// File: rtl/bcd_result_display.sv
// bcd_result_display: resolves sign of a two-digit BCD result and drives three active-low 7-segment displays.
module bcd_result_display #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                 CLOCK_50,
  input  logic                 RST,
  bcd_result_display_if.slave  bus,
  output logic [6:0]           HEX0,
  output logic [6:0]           HEX1,
  output logic [6:0]           HEX2,
  output logic                 busy
);
  localparam int CW = $clog2(BLINK_DIV + 1);
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_ONE   = 7'b1001111;
  typedef enum logic [2:0] {IDLE, CHECK, COMPL_LO, COMPL_HI, DRIVE, ERR} state_t;
  state_t state, state_nx;
  logic [3:0] tens, units;
  logic carry_q, sub_q, neg, z, phase, xfer;
  logic [CW-1:0] cnt;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0001100;
      default: seg = SEG_BLANK;
    endcase
  endfunction
  assign bus.in_ready = (state == IDLE) || (state == ERR);
  assign busy = !bus.in_ready;
  assign xfer = bus.in_valid && bus.in_ready;
  always_ff @(posedge CLOCK_50)
    state <= RST ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = xfer ? CHECK : IDLE;
      CHECK:    state_nx = (tens > 4'd9 || units > 4'd9) ? ERR :
                           (sub_q && !carry_q && {tens, units} != 8'h00) ? COMPL_LO : DRIVE;
      COMPL_LO: state_nx = COMPL_HI;
      COMPL_HI: state_nx = DRIVE;
      DRIVE:    state_nx = IDLE;
      ERR:      state_nx = xfer ? CHECK : ERR;
      default:  state_nx = IDLE;
    endcase
  end
  // Magnitude of a negative result: 10's complement done units first, borrow tracked in z.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      tens    <= '0;
      units   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      neg     <= 1'b0;
      z       <= 1'b0;
      phase   <= 1'b0;
      cnt     <= '0;
      HEX0    <= SEG_BLANK;
      HEX1    <= SEG_BLANK;
      HEX2    <= SEG_BLANK;
    end else begin
      if (xfer) begin
        tens    <= bus.result[7:4];
        units   <= bus.result[3:0];
        carry_q <= bus.carry;
        sub_q   <= bus.mode_sub;
      end
      case (state)
        CHECK: begin
          neg   <= state_nx == COMPL_LO;
          cnt   <= '0;
          phase <= 1'b0;
        end
        COMPL_LO: begin
          units <= (units == 4'd0) ? 4'd0 : 4'd10 - units;
          z     <= units == 4'd0;
        end
        COMPL_HI: tens <= z ? ((tens == 4'd0) ? 4'd0 : 4'd10 - tens) : 4'd9 - tens;
        DRIVE: begin
          HEX1 <= seg(tens);
          HEX0 <= seg(units);
          HEX2 <= neg ? SEG_MINUS : (!sub_q && carry_q) ? SEG_ONE : SEG_BLANK;
        end
        ERR: begin
          HEX2  <= SEG_BLANK;
          HEX1  <= phase ? SEG_BLANK : SEG_E;
          HEX0  <= phase ? SEG_BLANK : SEG_E;
          cnt   <= (cnt == CW'(BLINK_DIV - 1)) ? '0 : cnt + 1'b1;
          phase <= (cnt == CW'(BLINK_DIV - 1)) ? ~phase : phase;
        end
        default: ;
      endcase
    end
  end
endmodule
